gsim_core_param: RTL and testbench



---
 rtl/gsim_pkg.sv | 25 ++
 rtl/gsim_sat.sv | 27 ++
 rtl/gsim_core_param.sv | 165 ++++++++++++++++
 tb/tb_gsim_core_param.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// Shared definitions for the Gauss-Seidel x-vector update core: op
// encodings, default parameter values and a small op classifier.
package gsim_pkg;

  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_MUL      = 2'b01,
    OP_SUB      = 2'b10,
    OP_SUB_LAST = 2'b11
  } gsim_op_e;

  localparam int DEF_N_X       = 4;
  localparam int DEF_X_W       = 32;
  localparam int DEF_X_FRAC    = 16;
  localparam int DEF_COEF_W    = 16;
  localparam int DEF_COEF_FRAC = 16;
  localparam int DEF_EXT_W     = 5;
  localparam int DEF_SAT       = 1;

  // True for both subtract flavours; they share the D2/D3 datapath.
  function automatic logic is_sub(input gsim_op_e op);
    return (op == OP_SUB) || (op == OP_SUB_LAST);
  endfunction

endpackage

// File: rtl/gsim_sat.sv
// Combinational narrowing of a signed ACC_W value to X_W bits. o_ovf flags
// any value outside the signed X_W range; the output saturates when SAT is
// nonzero and simply keeps the low bits otherwise.
module gsim_sat #(
  parameter int X_W   = 32,
  parameter int ACC_W = 37,
  parameter int SAT   = 1
) (
  input  logic [ACC_W-1:0] i_din,
  output logic [X_W-1:0]   o_dout,
  output logic             o_ovf
);

  logic [ACC_W-X_W:0] upper;

  // The value fits when every bit from X_W-1 upward equals the sign bit.
  always_comb begin
    upper  = i_din[ACC_W-1:X_W-1];
    o_ovf  = !((&upper) || (~|upper));
    o_dout = i_din[X_W-1:0];
    if (o_ovf && (SAT != 0)) begin
      if (i_din[ACC_W-1]) o_dout = {1'b1, {(X_W-1){1'b0}}};
      else                o_dout = {1'b0, {(X_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/gsim_core_param.sv
// Parametrised x-vector update core. Holds N_X signed fixed-point entries
// and runs a 3-stage MUL/SUB pipeline on them:
//   D1: operands registered, product P = a*b formed
//   D2: Q = P >>> COEF_FRAC; MUL writes x, SUB computes minuend - Q
//   D3: SUB / SUB_LAST difference written back (SUB_LAST narrowed)
// A SUB in D2 takes its minuend from D3 when D3 is about to write the same
// entry, so back-to-back subtracts on one entry chain correctly.
//
// Op handshake: i_op_valid qualifies i_op/i_idx/i_a/i_b/i_zero in the cycle
// it is high. There is no ready; every valid op is accepted that cycle and
// the issuer is responsible for not colliding loads with pending writes.
module gsim_core_param
  import gsim_pkg::*;
#(
  parameter int N_X       = DEF_N_X,
  parameter int X_W       = DEF_X_W,
  parameter int X_FRAC    = DEF_X_FRAC,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int COEF_FRAC = DEF_COEF_FRAC,
  parameter int EXT_W     = DEF_EXT_W,
  parameter int SAT       = DEF_SAT,
  localparam int IDX_W    = (N_X > 1) ? $clog2(N_X) : 1,
  localparam int B_W      = X_W - X_FRAC,
  localparam int ACC_W    = X_W + EXT_W
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_op_valid,
  input  logic [1:0]           i_op,
  input  logic [IDX_W-1:0]     i_idx,
  input  logic [X_W-1:0]       i_a,
  input  logic [COEF_W-1:0]    i_b,
  input  logic                 i_zero,
  input  logic                 i_b_ins,
  input  logic [N_X*B_W-1:0]   i_b_ins_data,
  input  logic                 i_b_up,
  input  logic [IDX_W-1:0]     i_b_up_idx,
  input  logic [B_W-1:0]       i_b_up_data,
  input  logic                 i_ovf_clr,
  output logic [N_X*X_W-1:0]   o_x_data,
  output logic [X_W-1:0]       o_mul_forw,
  output logic [X_W-1:0]       o_sub_forw,
  output logic                 o_sub_for_val,
  output logic                 o_ovf,
  output logic                 o_busy
);

  localparam int PW = X_W + COEF_W;

  // Stage ops (reset) and operands (not reset)
  gsim_op_e                 d1_op, d2_op, d3_op;
  logic [IDX_W-1:0]         d1_idx, d2_idx, d3_idx;
  logic signed [X_W-1:0]    d1_a;
  logic signed [COEF_W-1:0] d1_b;
  logic                     d1_zero, d2_zero;
  logic signed [PW-1:0]     d1_p, d2_p;
  logic signed [ACC_W-1:0]  d2_q, d2_min, d2_diff, d3_diff, d3_wval;
  logic [ACC_W-1:0]         rf_val;
  logic                     d2_fwd;
  logic [X_W-1:0]           d3_narrow;
  logic                     d3_ovf;

  // Register file: X_W value plus EXT_W guard bits per entry
  logic [X_W-1:0]           x_q   [N_X];
  logic [EXT_W-1:0]         ext_q [N_X];

  // Stage op tracking; reset drops every op in flight so nothing writes late
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      d1_op <= OP_NOP;
      d2_op <= OP_NOP;
      d3_op <= OP_NOP;
    end else begin
      d1_op <= i_op_valid ? gsim_op_e'(i_op) : OP_NOP;
      d2_op <= d1_op;
      d3_op <= d2_op;
    end
  end

  // Operand pipeline; D1 operands hold while no op is presented
  always_ff @(posedge i_clk) begin
    if (i_op_valid) begin
      d1_idx  <= i_idx;
      d1_a    <= i_a;
      d1_b    <= i_b;
      d1_zero <= i_zero;
    end
    d2_idx  <= d1_idx;
    d2_zero <= d1_zero;
    d2_p    <= d1_p;
    d3_idx  <= d2_idx;
    d3_diff <= d2_diff;
  end

  // D1 product at full width, so the D2 shift sees every bit
  always_comb begin
    d1_p = PW'(d1_a) * PW'(d1_b);
  end

  // D2: scale the product, choose the minuend and subtract
  always_comb begin
    d2_q   = d2_zero ? '0 : ACC_W'(d2_p >>> COEF_FRAC);
    rf_val = '0;
    for (int i = 0; i < N_X; i++) begin
      if (IDX_W'(i) == d2_idx) rf_val = {ext_q[i], x_q[i]};
    end
    d2_fwd  = is_sub(d3_op) && (d3_idx == d2_idx);
    d2_min  = d2_fwd ? d3_wval : rf_val;
    d2_diff = d2_min - d2_q;
  end

  gsim_sat #(
    .X_W   (X_W),
    .ACC_W (ACC_W),
    .SAT   (SAT)
  ) u_sat (
    .i_din  (d3_diff),
    .o_dout (d3_narrow),
    .o_ovf  (d3_ovf)
  );

  // D3 write value: SUB keeps the full accumulator, SUB_LAST the narrowed one
  always_comb begin
    if (d3_op == OP_SUB_LAST) d3_wval = {{EXT_W{d3_narrow[X_W-1]}}, d3_narrow};
    else                      d3_wval = d3_diff;
  end

  // Per-entry writes: reset > bulk load > single load > D2 MUL > D3 SUB
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < N_X; i++) begin
      if (i_reset) begin
        x_q[i]   <= '0;
        ext_q[i] <= '0;
      end else if (i_b_ins) begin
        x_q[i]   <= {i_b_ins_data[i*B_W +: B_W], {X_FRAC{1'b0}}};
        ext_q[i] <= {EXT_W{i_b_ins_data[i*B_W + B_W - 1]}};
      end else if (i_b_up && (i_b_up_idx == IDX_W'(i))) begin
        x_q[i]   <= {i_b_up_data, {X_FRAC{1'b0}}};
        ext_q[i] <= {EXT_W{i_b_up_data[B_W-1]}};
      end else if ((d2_op == OP_MUL) && (d2_idx == IDX_W'(i))) begin
        x_q[i]   <= d2_q[X_W-1:0];
        ext_q[i] <= {EXT_W{d2_q[X_W-1]}};
      end else if (is_sub(d3_op) && (d3_idx == IDX_W'(i))) begin
        {ext_q[i], x_q[i]} <= d3_wval;
      end
    end
  end

  // Sticky overflow from SUB_LAST narrowing; a new overflow beats a clear
  always_ff @(posedge i_clk) begin
    if (i_reset)                               o_ovf <= 1'b0;
    else if ((d3_op == OP_SUB_LAST) && d3_ovf) o_ovf <= 1'b1;
    else if (i_ovf_clr)                        o_ovf <= 1'b0;
  end

  // Flatten the register file and expose the forwarding/status views
  always_comb begin
    for (int i = 0; i < N_X; i++) o_x_data[i*X_W +: X_W] = x_q[i];
    o_mul_forw    = d2_q[X_W-1:0];
    o_sub_forw    = d3_narrow;
    o_sub_for_val = is_sub(d1_op) && is_sub(d2_op) && is_sub(d3_op);
    o_busy        = (d1_op != OP_NOP) || (d2_op != OP_NOP) || (d3_op != OP_NOP);
  end

endmodule

// File: tb/tb_gsim_core_param.sv
// Directed bench for gsim_core_param: a table of isolated single-op vectors
// run against a saturating and a wrapping instance, plus hand-written
// sequences for timing, forwarding, load priority, overflow and reset.
module tb_gsim_core_param;
  import gsim_pkg::*;

  localparam int N_X = 4;
  localparam int X_W = 32;
  localparam int B_W = 16;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  logic                 i_op_valid;
  logic [1:0]           i_op;
  logic [1:0]           i_idx;
  logic [31:0]          i_a;
  logic [15:0]          i_b;
  logic                 i_zero;
  logic                 i_b_ins;
  logic [N_X*B_W-1:0]   i_b_ins_data;
  logic                 i_b_up;
  logic [1:0]           i_b_up_idx;
  logic [B_W-1:0]       i_b_up_data;
  logic                 i_ovf_clr;

  logic [N_X*X_W-1:0]   s_x_data,   w_x_data;
  logic [X_W-1:0]       s_mul_forw, w_mul_forw;
  logic [X_W-1:0]       s_sub_forw, w_sub_forw;
  logic                 s_sub_for_val, w_sub_for_val;
  logic                 s_ovf, w_ovf;
  logic                 s_busy, w_busy;

  gsim_core_param #(.SAT(1)) u_dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_op_valid(i_op_valid), .i_op(i_op),
    .i_idx(i_idx), .i_a(i_a), .i_b(i_b), .i_zero(i_zero), .i_b_ins(i_b_ins),
    .i_b_ins_data(i_b_ins_data), .i_b_up(i_b_up), .i_b_up_idx(i_b_up_idx),
    .i_b_up_data(i_b_up_data), .i_ovf_clr(i_ovf_clr), .o_x_data(s_x_data),
    .o_mul_forw(s_mul_forw), .o_sub_forw(s_sub_forw),
    .o_sub_for_val(s_sub_for_val), .o_ovf(s_ovf), .o_busy(s_busy)
  );

  gsim_core_param #(.SAT(0)) u_dut_wrap (
    .i_clk(i_clk), .i_reset(i_reset), .i_op_valid(i_op_valid), .i_op(i_op),
    .i_idx(i_idx), .i_a(i_a), .i_b(i_b), .i_zero(i_zero), .i_b_ins(i_b_ins),
    .i_b_ins_data(i_b_ins_data), .i_b_up(i_b_up), .i_b_up_idx(i_b_up_idx),
    .i_b_up_data(i_b_up_data), .i_ovf_clr(i_ovf_clr), .o_x_data(w_x_data),
    .o_mul_forw(w_mul_forw), .o_sub_forw(w_sub_forw),
    .o_sub_for_val(w_sub_for_val), .o_ovf(w_ovf), .o_busy(w_busy)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare against the oldest queued expectation
  task automatic chk_q(input string name, input logic [63:0] act);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: expected queue empty, got 0x%0h", name, act);
    end else begin
      e = exp_q.pop_front();
      chk(name, act, e);
    end
  endtask

  function automatic logic [31:0] ent(input logic [N_X*X_W-1:0] bus, input int i);
    return bus[i*X_W +: X_W];
  endfunction

  // ---------------- drivers ----------------
  // Advance one cycle; outputs are then stable for the new cycle
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] idx,
                       input logic [31:0] a, input logic [15:0] b, input logic z);
    i_op_valid = 1'b1;
    i_op       = op;
    i_idx      = idx;
    i_a        = a;
    i_b        = b;
    i_zero     = z;
  endtask

  task automatic no_op();
    i_op_valid = 1'b0;
    i_op       = OP_NOP;
  endtask

  task automatic load_one(input logic [1:0] idx, input logic [15:0] v);
    i_b_up      = 1'b1;
    i_b_up_idx  = idx;
    i_b_up_data = v;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [1:0]  idx;
    logic [31:0] a;
    logic [15:0] b;
    logic        zero;
    logic [15:0] pre;
    logic [31:0] exp_sat;
    logic [31:0] exp_wrap;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{OP_MUL,      2'd2, 32'h0003_0000, 16'h5555, 1'b0, 16'h0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0};
    vecs[1] = '{OP_MUL,      2'd1, 32'hFFFE_0000, 16'h4000, 1'b0, 16'h0000, 32'hFFFF_8000, 32'hFFFF_8000, 1'b0};
    vecs[2] = '{OP_MUL,      2'd0, 32'h0003_0000, 16'h8000, 1'b0, 16'h0000, 32'hFFFE_8000, 32'hFFFE_8000, 1'b0};
    vecs[3] = '{OP_MUL,      2'd3, 32'h0001_0000, 16'h4000, 1'b1, 16'h0007, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[4] = '{OP_SUB,      2'd0, 32'h0001_0000, 16'h4000, 1'b0, 16'h0005, 32'h0004_C000, 32'h0004_C000, 1'b0};
    vecs[5] = '{OP_SUB_LAST, 2'd3, 32'h0001_0000, 16'h7FFF, 1'b0, 16'hFFFF, 32'hFFFE_8001, 32'hFFFE_8001, 1'b0};
    vecs[6] = '{OP_MUL,      2'd1, 32'hFFFF_FFFF, 16'h0001, 1'b0, 16'h0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[7] = '{OP_SUB_LAST, 2'd2, 32'h0001_0000, 16'h0001, 1'b0, 16'h8000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
  end

  // ---------------- test ----------------
  initial begin
    i_reset = 1'b1;
    i_op_valid = 1'b0; i_op = OP_NOP; i_idx = '0; i_a = '0; i_b = '0; i_zero = 1'b0;
    i_b_ins = 1'b0; i_b_ins_data = '0; i_b_up = 1'b0; i_b_up_idx = '0;
    i_b_up_data = '0; i_ovf_clr = 1'b0;
    tick();
    tick();

    // Reset state
    chk("reset_x",        s_x_data, '0);
    chk("reset_ovf",      s_ovf, 1'b0);
    chk("reset_busy",     s_busy, 1'b0);
    chk("reset_sfv",      s_sub_for_val, 1'b0);
    i_reset = 1'b0;

    // Bulk load {4,3,2,1}
    i_b_ins      = 1'b1;
    i_b_ins_data = {16'd4, 16'd3, 16'd2, 16'd1};
    tick();
    i_b_ins = 1'b0;
    exp_q.push_back(64'h0001_0000);
    exp_q.push_back(64'h0002_0000);
    exp_q.push_back(64'h0003_0000);
    exp_q.push_back(64'h0004_0000);
    for (int i = 0; i < N_X; i++) chk_q($sformatf("bulk_x%0d", i), ent(s_x_data, i));

    // MUL timing: forward in cycle 2, register in cycle 3
    issue(OP_MUL, 2'd2, 32'h0003_0000, 16'h5555, 1'b0);
    tick();
    no_op();
    chk("mul_busy_c1", s_busy, 1'b1);
    tick();
    chk("mul_forw_c2", s_mul_forw, 32'h0000_FFFF);
    chk("mul_x2_c2",   ent(s_x_data, 2), 32'h0003_0000);
    tick();
    chk("mul_x2_c3",   ent(s_x_data, 2), 32'h0000_FFFF);

    // Table of isolated ops
    for (int v = 0; v < 8; v++) begin
      load_one(vecs[v].idx, vecs[v].pre);
      i_ovf_clr = 1'b1;
      tick();
      i_b_up = 1'b0;
      i_ovf_clr = 1'b0;
      issue(vecs[v].op, vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].zero);
      tick();
      no_op();
      tick();
      tick();
      tick();
      chk($sformatf("vec%0d_x_sat", v),  ent(s_x_data, vecs[v].idx), vecs[v].exp_sat);
      chk($sformatf("vec%0d_x_wrap", v), ent(w_x_data, vecs[v].idx), vecs[v].exp_wrap);
      chk($sformatf("vec%0d_ovf", v),    s_ovf, vecs[v].exp_ovf);
      chk($sformatf("vec%0d_busy", v),   s_busy, 1'b0);
    end

    // Back-to-back SUB, SUB, SUB_LAST on idx0 (forwarding)
    load_one(2'd0, 16'h0001);
    i_ovf_clr = 1'b1;
    tick();
    i_b_up = 1'b0;
    i_ovf_clr = 1'b0;
    issue(OP_SUB, 2'd0, 32'h0001_0000, 16'h4000, 1'b0);
    tick();
    issue(OP_SUB, 2'd0, 32'h0001_0000, 16'h4000, 1'b0);
    tick();
    issue(OP_SUB_LAST, 2'd0, 32'h0001_0000, 16'h4000, 1'b0);
    chk("b2b_sfv_c2", s_sub_for_val, 1'b0);
    tick();
    no_op();
    chk("b2b_sfv_c3",  s_sub_for_val, 1'b1);
    chk("b2b_forw_c3", s_sub_forw, 32'h0000_C000);
    tick();
    tick();
    tick();
    chk("b2b_x0", ent(s_x_data, 0), 32'h0000_4000);

    // Gap of one cycle between SUBs on idx1 (register file path)
    load_one(2'd1, 16'h0001);
    tick();
    i_b_up = 1'b0;
    issue(OP_SUB, 2'd1, 32'h0001_0000, 16'h4000, 1'b0);
    tick();
    no_op();
    tick();
    issue(OP_SUB, 2'd1, 32'h0001_0000, 16'h4000, 1'b0);
    tick();
    no_op();
    tick();
    tick();
    tick();
    chk("gap_x1", ent(s_x_data, 1), 32'h0000_8000);

    // MUL then SUB on idx3, one cycle apart
    issue(OP_MUL, 2'd3, 32'h0004_0000, 16'h4000, 1'b0);
    tick();
    issue(OP_SUB, 2'd3, 32'h0001_0000, 16'h4000, 1'b0);
    tick();
    no_op();
    tick();
    tick();
    tick();
    chk("mulsub_x3", ent(s_x_data, 3), 32'h0000_C000);

    // SUB_LAST overflow: saturate vs wrap, sticky flag, clear
    load_one(2'd1, 16'h7FFF);
    tick();
    i_b_up = 1'b0;
    issue(OP_SUB_LAST, 2'd1, 32'h8000_0000, 16'h7FFF, 1'b0);
    tick();
    no_op();
    tick();
    tick();
    tick();
    chk("ovf_x1_sat",  ent(s_x_data, 1), 32'h7FFF_FFFF);
    chk("ovf_x1_wrap", ent(w_x_data, 1), 32'hBFFE_8000);
    chk("ovf_sat",     s_ovf, 1'b1);
    chk("ovf_wrap",    w_ovf, 1'b1);
    tick();
    chk("ovf_sticky",  s_ovf, 1'b1);
    i_ovf_clr = 1'b1;
    tick();
    i_ovf_clr = 1'b0;
    chk("ovf_clr_sat",  s_ovf, 1'b0);
    chk("ovf_clr_wrap", w_ovf, 1'b0);

    // Clear in the same cycle as a new overflow: set wins (sat instance only overflows)
    issue(OP_SUB_LAST, 2'd1, 32'h8000_0000, 16'h7FFF, 1'b0);
    tick();
    no_op();
    tick();
    tick();
    i_ovf_clr = 1'b1;
    tick();
    i_ovf_clr = 1'b0;
    chk("setclr_ovf_sat",  s_ovf, 1'b1);
    chk("setclr_ovf_wrap", w_ovf, 1'b0);
    chk("setclr_x1_sat",   ent(s_x_data, 1), 32'h7FFF_FFFF);
    chk("setclr_x1_wrap",  ent(w_x_data, 1), 32'hFFFE_0000);

    // Single load beats a D2 MUL to the same entry
    issue(OP_MUL, 2'd3, 32'h0001_0000, 16'h4000, 1'b0);
    tick();
    no_op();
    tick();
    load_one(2'd3, 16'h0002);
    tick();
    i_b_up = 1'b0;
    chk("bup_vs_mul_x3", ent(s_x_data, 3), 32'h0002_0000);
    tick();
    chk("bup_vs_mul_x3_hold", ent(s_x_data, 3), 32'h0002_0000);

    // Reset with three SUBs in flight
    issue(OP_SUB, 2'd0, 32'h0001_0000, 16'h4000, 1'b0);
    tick();
    issue(OP_SUB, 2'd1, 32'h0001_0000, 16'h4000, 1'b0);
    tick();
    issue(OP_SUB, 2'd2, 32'h0001_0000, 16'h4000, 1'b0);
    tick();
    no_op();
    chk("rst_fl_sfv_pre", s_sub_for_val, 1'b1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("rst_fl_x",    s_x_data, '0);
    chk("rst_fl_busy", s_busy, 1'b0);
    chk("rst_fl_ovf",  s_ovf, 1'b0);
    chk("rst_fl_sfv",  s_sub_for_val, 1'b0);
    tick();
    tick();
    tick();
    tick();
    chk("rst_fl_x_later",      s_x_data, '0);
    chk("rst_fl_x_wrap_later", w_x_data, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
